// File: rtl/gpr_read_sequencer_pkg.sv
// Shared GPR geometry, data types and FSM encoding for the operand-read sequencer.
// Every file in this block imports these definitions instead of declaring its own.
package gpr_read_sequencer_pkg;

  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int NUM_REGS    = 64;
  localparam int DATAW       = 32;

  localparam int NW_BITS   = $clog2(NUM_WARPS);
  localparam int NR_BITS   = $clog2(NUM_REGS);
  localparam int GPR_AW    = NW_BITS + NR_BITS;
  localparam int GPR_DEPTH = NUM_WARPS * NUM_REGS;
  localparam int VEC_W     = NUM_THREADS * DATAW;

  typedef logic [NW_BITS-1:0]     wid_t;
  typedef logic [NR_BITS-1:0]     reg_id_t;
  typedef logic [GPR_AW-1:0]      gpr_addr_t;
  typedef logic [NUM_THREADS-1:0] tmask_t;
  typedef logic [DATAW-1:0]       lane_t;
  typedef logic [VEC_W-1:0]       vec_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_HOLD
  } seq_state_e;

  // Request fields that must survive past the accept cycle.
  typedef struct packed {
    wid_t    wid;
    reg_id_t rs3;
    logic    use_rs3;
  } req_ctx_t;

  function automatic gpr_addr_t gpr_addr(wid_t wid, reg_id_t rs);
    return {wid, rs};
  endfunction

endpackage

// File: rtl/gpr_read_sequencer_if.sv
// Issue-side request, GPR RAM read ports, writeback snoop and dispatch-side response.
// The sequencer uses the slave view; the surrounding core uses the master view.
interface gpr_read_sequencer_if;
  import gpr_read_sequencer_pkg::*;

  logic      req_valid;
  logic      req_ready;
  wid_t      req_wid;
  reg_id_t   req_rs1;
  reg_id_t   req_rs2;
  reg_id_t   req_rs3;
  logic      req_use_rs3;

  gpr_addr_t gpr_raddr1;
  gpr_addr_t gpr_raddr2;
  vec_t      gpr_rdata1;
  vec_t      gpr_rdata2;

  logic      wb_valid;
  wid_t      wb_wid;
  reg_id_t   wb_rd;
  tmask_t    wb_tmask;
  vec_t      wb_data;

  logic      rsp_valid;
  logic      rsp_ready;
  wid_t      rsp_wid;
  vec_t      rsp_rs1_data;
  vec_t      rsp_rs2_data;
  vec_t      rsp_rs3_data;

  modport slave (
    input  req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3,
    output req_ready,
    output gpr_raddr1, gpr_raddr2,
    input  gpr_rdata1, gpr_rdata2,
    input  wb_valid, wb_wid, wb_rd, wb_tmask, wb_data,
    output rsp_valid, rsp_wid, rsp_rs1_data, rsp_rs2_data, rsp_rs3_data,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3,
    input  req_ready,
    input  gpr_raddr1, gpr_raddr2,
    output gpr_rdata1, gpr_rdata2,
    output wb_valid, wb_wid, wb_rd, wb_tmask, wb_data,
    input  rsp_valid, rsp_wid, rsp_rs1_data, rsp_rs2_data, rsp_rs3_data,
    output rsp_ready
  );

endinterface

// File: rtl/gpr_read_sequencer_fwd_merge.sv
// One read port's writeback bypass: snoop the writeback while the address is on the RAM,
// then overlay the snooped lanes onto the read-first RAM data the following cycle.
module gpr_fwd_merge
  import gpr_read_sequencer_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_addr_valid,
  input  gpr_addr_t i_addr,
  input  logic      i_wb_valid,
  input  wid_t      i_wb_wid,
  input  reg_id_t   i_wb_rd,
  input  tmask_t    i_wb_tmask,
  input  vec_t      i_wb_data,
  input  vec_t      i_rdata,
  output vec_t      o_data
);

  logic   w_hit;
  tmask_t r_tmask;
  vec_t   r_data;

  // r0 is never bypassed: its reads return whatever the RAM holds.
  assign w_hit = i_addr_valid && i_wb_valid && (i_wb_rd != '0)
              && (gpr_addr(i_wb_wid, i_wb_rd) == i_addr);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tmask <= '0;
      r_data  <= '0;
    end else begin
      r_tmask <= w_hit ? i_wb_tmask : '0;
      if (w_hit) begin
        r_data <= i_wb_data;
      end
    end
  end

  // NOTE: the output gets a full default before any lane override, so no latch is inferred.
  always_comb begin
    o_data = i_rdata;
    for (int l = 0; l < NUM_THREADS; l++) begin
      if (r_tmask[l]) begin
        o_data[l*DATAW +: DATAW] = r_data[l*DATAW +: DATAW];
      end
    end
  end

endmodule

// File: rtl/gpr_read_sequencer.sv
// Sequences one operand-read request onto two synchronous GPR read ports (rs3 takes a
// second cycle on port 1), merges same-cycle writebacks and holds results for dispatch.
module gpr_read_sequencer
  import gpr_read_sequencer_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  gpr_read_sequencer_if.slave bus
);

  seq_state_e r_state;
  req_ctx_t   r_ctx;
  logic       r_rsp_valid;
  vec_t       r_rs1;
  vec_t       r_rs2;
  vec_t       r_rs3;

  logic      w_req_ready;
  logic      w_accept;
  logic      w_rd1_valid;
  logic      w_rd2_valid;
  gpr_addr_t w_raddr1;
  gpr_addr_t w_raddr2;
  vec_t      w_op1;
  vec_t      w_op2;
  req_ctx_t  w_req_ctx;

  // A held response may be replaced in the same cycle the consumer takes it.
  assign w_req_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.rsp_ready);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_req_ctx   = '{wid: bus.req_wid, rs3: bus.req_rs3, use_rs3: bus.req_use_rs3};

  always_comb begin
    w_rd1_valid = 1'b0;
    w_rd2_valid = 1'b0;
    w_raddr1    = '0;
    w_raddr2    = '0;
    if (w_accept) begin
      w_rd1_valid = 1'b1;
      w_rd2_valid = 1'b1;
      w_raddr1    = gpr_addr(bus.req_wid, bus.req_rs1);
      w_raddr2    = gpr_addr(bus.req_wid, bus.req_rs2);
    end else if ((r_state == S_RD_A) && r_ctx.use_rs3) begin
      w_rd1_valid = 1'b1;
      w_raddr1    = gpr_addr(r_ctx.wid, r_ctx.rs3);
    end
  end

  gpr_fwd_merge u_fwd1 (
    .clk          (clk),
    .reset        (reset),
    .i_addr_valid (w_rd1_valid),
    .i_addr       (w_raddr1),
    .i_wb_valid   (bus.wb_valid),
    .i_wb_wid     (bus.wb_wid),
    .i_wb_rd      (bus.wb_rd),
    .i_wb_tmask   (bus.wb_tmask),
    .i_wb_data    (bus.wb_data),
    .i_rdata      (bus.gpr_rdata1),
    .o_data       (w_op1)
  );

  gpr_fwd_merge u_fwd2 (
    .clk          (clk),
    .reset        (reset),
    .i_addr_valid (w_rd2_valid),
    .i_addr       (w_raddr2),
    .i_wb_valid   (bus.wb_valid),
    .i_wb_wid     (bus.wb_wid),
    .i_wb_rd      (bus.wb_rd),
    .i_wb_tmask   (bus.wb_tmask),
    .i_wb_data    (bus.wb_data),
    .i_rdata      (bus.gpr_rdata2),
    .o_data       (w_op2)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ctx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs3       <= '0;
    end else begin
      if (w_accept) begin
        r_ctx <= w_req_ctx;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RD_A;
          end
        end
        S_RD_A: begin
          r_rs1 <= w_op1;
          r_rs2 <= w_op2;
          if (r_ctx.use_rs3) begin
            r_state <= S_RD_B;
          end else begin
            r_rs3       <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_RD_B: begin
          r_rs3       <= w_op1;
          r_rsp_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= bus.req_valid ? S_RD_A : S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.gpr_raddr1   = w_raddr1;
  assign bus.gpr_raddr2   = w_raddr2;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_wid      = r_ctx.wid;
  assign bus.rsp_rs1_data = r_rs1;
  assign bus.rsp_rs2_data = r_rs2;
  assign bus.rsp_rs3_data = r_rs3;

endmodule

// File: doc/gpr_read_sequencer.md
Name: gpr_read_sequencer

Overview:
- Sits between issue and the per-thread GPR RAM banks, which have 2 synchronous read ports.
- Accepts one operand-read request per instruction (wid, rs1, rs2, optional rs3 for fused FP ops) and sequences port use: rs1/rs2 in one cycle, rs3 on port 1 in a second cycle.
- Forwards same-cycle writeback data that collides with the read, and holds assembled operands until the dispatch consumer accepts them.

Parameters:
NUM_THREADS, 4, lanes per warp
NUM_WARPS, 4, warps per core
NUM_REGS, 64, registers per warp (int+fp)
DATAW, 32, bits per lane

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  operand-read request valid
req_ready  out  1  request accepted when valid&ready
req_wid  in  log2(NUM_WARPS)  warp id
req_rs1/req_rs2/req_rs3  in  log2(NUM_REGS) each  source register ids
req_use_rs3  in  1  instruction needs third operand
gpr_raddr1/gpr_raddr2  out  log2(NUM_WARPS*NUM_REGS) each  RAM read address {wid,rs}
gpr_rdata1/gpr_rdata2  in  NUM_THREADS*DATAW each  RAM read data, valid 1 cycle after address
wb_valid  in  1  writeback valid
wb_wid  in  log2(NUM_WARPS)  writeback warp
wb_rd  in  log2(NUM_REGS)  writeback register
wb_tmask  in  NUM_THREADS  lanes written
wb_data  in  NUM_THREADS*DATAW  writeback data
rsp_valid  out  1  operands valid
rsp_ready  in  1  consumer accepts
rsp_wid  out  log2(NUM_WARPS)  warp of response
rsp_rs1_data/rsp_rs2_data/rsp_rs3_data  out  NUM_THREADS*DATAW each  operands

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; rsp_valid=0; rsp_wid and all data buffers=0; forward flags=0. Reset mid-sequence abandons the request; nothing is emitted.
- FSM states:
  - IDLE: req_ready=1.
  - RD_A: rs1/rs2 data in flight.
  - RD_B: rs3 in flight.
  - HOLD: rsp_valid=1.
- req_ready = (state==IDLE) || (state==HOLD && rsp_ready). Never asserted in RD_A/RD_B.
- Accept cycle: gpr_raddr1={req_wid,req_rs1} and gpr_raddr2={req_wid,req_rs2}, driven combinationally from req. Latch wid, rs3, and use_rs3. Next state RD_A.
- RD_A:
  - Capture gpr_rdata1→rs1 buffer and gpr_rdata2→rs2 buffer (after forwarding).
  - If use_rs3: drive gpr_raddr1={wid,rs3} and go to RD_B.
  - Else: rs3 buffer=0 and go to HOLD.
- RD_B: capture gpr_rdata1→rs3 buffer and go to HOLD.
- HOLD:
  - Outputs are stable while rsp_valid && !rsp_ready.
  - rsp_ready && req_valid: back-to-back accept, next state RD_A.
  - rsp_ready && !req_valid: go to IDLE.
- Latency, accept to rsp_valid: 2 cycles without rs3, 3 with rs3. Peak throughput is 1 request per 2 cycles (no rs3) or per 3 cycles (rs3).
- In cycles where no read is sequenced, raddr outputs are don't-care; they are driven to 0.
- Forwarding: the RAM is read-first, so a same-cycle write returns old data.
  - In every cycle an address is presented, each port compares against wb_valid && wb_rd!=0 && {wb_wid,wb_rd}==addr.
  - On a match, register wb_tmask and wb_data for that port.
  - At capture, lanes with the registered tmask bit set take the forwarded data; other lanes take RAM data.
- A writeback to rd==0 is never forwarded. Register 0 reads whatever the RAM returns.
- Writebacks arriving while in HOLD are not merged; the scoreboard guarantees no such hazard.
- rs1==rs2: both ports forward independently and identically.

Decomposition:
- Shared definitions (NW_BITS, NR_BITS, GPR address width, per-lane data type) belong in the common VX define package. Do not redefine them locally.
- One natural sub-module: gpr_fwd_merge. Per port it does the address compare, registers tmask and data, and performs the lane mux at capture. It is instantiated twice.
- The FSM and buffers stay in gpr_read_sequencer.

Test Plan:
- Reset: hold reset=0 for 3 cycles, with req_valid=1 → rsp_valid=0, req_ready=1 after release, all rsp data 0.
- Basic two-operand read: preload w1 r5=0x11 and w1 r6=0x22 on all lanes. Issue wid=1, rs1=5, rs2=6, use_rs3=0 → raddr1=0x45 and raddr2=0x46 in the accept cycle. rsp_valid 2 cycles later with rs1=0x11, rs2=0x22, rs3=0.
- FMA read: use_rs3=1, rs3=7 holding 0x33 → raddr1=0x47 in the RD_A cycle. rsp_valid 3 cycles after accept with rs3=0x33. req_ready stays low during RD_A/RD_B.
- Forwarding: in the accept cycle, writeback w1 r5=0xAA with tmask=0101 while the RAM still holds 0x11 → rs1 lanes 0,2 = 0xAA and lanes 1,3 = 0x11. A writeback with rd=0 in the same cycle is not forwarded.
- Backpressure: hold rsp_ready=0 for 4 cycles → rsp data and wid stable and req_ready=0. On rsp_ready=1 with a pending request, the new request is accepted in the same cycle and the next rsp arrives 2 cycles later.
- Reset mid-op: assert reset=0 during RD_B → the next cycle is IDLE with rsp_valid=0. The response for the abandoned request never appears.
